// File: rtl/spi_type_pkg.sv
// Shared SPI controller types: frame-width limit and the transfer-counter state encoding.
package spi_type_pkg;
    localparam int SPI_MAX_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        XC_IDLE = 2'd0,
        XC_RUN  = 2'd1,
        XC_DONE = 2'd2
    } xfer_cnt_state_t;
endpackage

// File: rtl/sync_flex_counter.sv
// Up-counter 0..rollover_val that wraps to 0 when enabled at rollover_val.
// rollover_flag is high whenever count_out equals rollover_val.
module sync_flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            count_next = (count_reg == rollover_val) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_out     = count_reg;
    assign rollover_flag = (count_reg == rollover_val);
endmodule

// File: rtl/spi_xfer_counters.sv
// SPI bit/frame/transfer counter with start/busy/done sequencing.
// Define SPI_XFER_CNT_LAST_EN to add the last_frame output.
module spi_xfer_counters
    import spi_type_pkg::*;
#(
    parameter int MAX_FRAME_BITS = SPI_MAX_FRAME_BITS,
    parameter int LEN_W          = 32,
    parameter int FB_W           = $clog2(MAX_FRAME_BITS + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             start,
    input  logic             count_enable,
    input  logic             count_clk,
    input  logic [FB_W-1:0]  frame_bits,
    input  logic [LEN_W-1:0] frame_len,
    output logic [FB_W-1:0]  bit_idx,
    output logic [LEN_W-1:0] frames_done,
    output logic             frame_done,
    output logic             xfer_done,
    output logic             busy,
`ifdef SPI_XFER_CNT_LAST_EN
    output logic             last_frame,
`endif
    output logic             done
);
    localparam logic [FB_W-1:0] MAX_BITS = FB_W'(MAX_FRAME_BITS);

    xfer_cnt_state_t  state_reg, state_next;
    logic [FB_W-1:0]  cfg_bits_reg;
    logic [LEN_W-1:0] cfg_len_reg;
    logic             frame_done_reg;
    logic             xfer_done_reg;

    logic [FB_W-1:0]  bits_norm;
    logic             arm;
    logic             strobe;
    logic             bit_flag;
    logic             frame_flag;
    logic             frame_complete;
    logic             last_pending;
    logic             xfer_complete;
    logic             cnt_clear;

    assign bits_norm = (frame_bits == '0 || frame_bits > MAX_BITS) ? MAX_BITS : frame_bits;

    // start only arms outside RUN, and clear always wins over it
    assign arm            = start & ~clear & (state_reg != XC_RUN);
    assign strobe         = count_enable & count_clk & ~clear & (state_reg == XC_RUN);
    assign frame_complete = strobe & bit_flag;
    assign last_pending   = (frames_done == cfg_len_reg - LEN_W'(1));
    assign xfer_complete  = frame_complete & last_pending;
    assign cnt_clear      = clear | arm;

    sync_flex_counter #(.WIDTH(FB_W)) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (strobe),
        .rollover_val (cfg_bits_reg - FB_W'(1)),
        .count_out    (bit_idx),
        .rollover_flag(bit_flag)
    );

    // Rollover at cfg_len is never taken: the frame count saturates at the transfer length
    sync_flex_counter #(.WIDTH(LEN_W)) u_frame_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (frame_complete & ~frame_flag),
        .rollover_val (cfg_len_reg),
        .count_out    (frames_done),
        .rollover_flag(frame_flag)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= XC_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            XC_IDLE, XC_DONE: begin
                if (clear) begin
                    state_next = XC_IDLE;
                end else if (start) begin
                    state_next = (frame_len == '0) ? XC_DONE : XC_RUN;
                end
            end
            XC_RUN: begin
                if (clear) begin
                    state_next = XC_IDLE;
                end else if (xfer_complete) begin
                    state_next = XC_DONE;
                end
            end
            default: state_next = XC_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == XC_RUN);
        done = (state_reg == XC_DONE);
`ifdef SPI_XFER_CNT_LAST_EN
        last_frame = (state_reg == XC_RUN) & last_pending;
`endif
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cfg_bits_reg <= '0;
            cfg_len_reg  <= '0;
        end else if (arm) begin
            cfg_bits_reg <= bits_norm;
            cfg_len_reg  <= frame_len;
        end
    end

    // A zero-length transfer completes straight from the start cycle
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            frame_done_reg <= 1'b0;
            xfer_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= frame_complete;
            xfer_done_reg  <= xfer_complete | (arm & (frame_len == '0));
        end
    end

    assign frame_done = frame_done_reg;
    assign xfer_done  = xfer_done_reg;
endmodule

// File: doc/spi_xfer_counters.md
Name: spi_xfer_counters

Overview:
Parametrised bit/frame counter for the SPI controller. It counts shift strobes into frames of a programmable bit length, and frames into a transfer of programmable length. It reports per-frame and per-transfer completion to the SPI FSM and the data path. It adds configurable frame width, start/busy/done sequencing, live counts, and zero-length handling.

Parameters:
MAX_FRAME_BITS, 32, largest supported frame width in bits (>=2)
LEN_W, 32, width of transfer-length and frame-count fields
FB_W, $clog2(MAX_FRAME_BITS+1), width of the frame_bits field; derived, do not override

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous active-low reset
clear  input  1  synchronous abort; return to IDLE, zero all counts
start  input  1  begin transfer; config latched this cycle
count_enable  input  1  shift path active
count_clk  input  1  one-cycle shift strobe; counted only when count_enable=1
frame_bits  input  FB_W  bits per frame, 1..MAX_FRAME_BITS; 0 or >MAX means MAX
frame_len  input  LEN_W  frames per transfer; 0 allowed
bit_idx  output  FB_W  bits shifted in the current frame
frames_done  output  LEN_W  frames completed in this transfer
frame_done  output  1  one-cycle pulse, frame completed
xfer_done  output  1  one-cycle pulse, transfer completed
busy  output  1  state==RUN
done  output  1  state==DONE, sticky

Behaviour:
- Reset: sampled only on a clk edge with n_rst=0. All outputs 0, state IDLE, latched config 0.
- Priority: n_rst > clear > start > strobe.
- States:
  - IDLE: start -> latch cfg_bits and cfg_len. frame_len=0 -> DONE with xfer_done pulse, no frame_done. Otherwise -> RUN.
  - RUN: start is ignored. A strobe (count_enable & count_clk) increments bit_idx.
  - DONE: start behaves as in IDLE (re-arm, counts zeroed). clear -> IDLE.
- Frame completion: on the strobe where bit_idx+1 == cfg_bits:
  - bit_idx <= 0 and frames_done <= frames_done+1.
  - frame_done=1 on the next cycle (registered, latency 1 from strobe).
- Transfer completion: if that frame makes frames_done == cfg_len:
  - xfer_done=1 in the same cycle as frame_done.
  - State -> DONE. busy drops and done rises in that same cycle.
- Strobes in IDLE or DONE are ignored. Inputs frame_bits and frame_len changing mid-RUN have no effect.
- cfg_bits=1: every strobe produces frame_done.
- Wrap: frames_done never exceeds cfg_len. The maximum value 2^LEN_W-1 is legal; no overflow.
- clear mid-RUN: next cycle is IDLE with all counts 0. No done pulses, including when clear coincides with a completing strobe.
- start and clear in the same cycle: clear wins and start is dropped.
- Pulses are never asserted for more than one cycle, including on back-to-back frames (strobe every cycle).

Optional Feature:
Macro SPI_XFER_CNT_LAST_EN.
- Defined: adds output last_frame (1 bit). It is high while busy and frames_done == cfg_len-1, so the SPI FSM can prepare CS deassertion. It is 0 in IDLE and DONE and on reset.
- Undefined: the port is absent. No extra logic is generated and all other behaviour is identical.

Decomposition:
- spi_type_pkg additions:
  - localparam SPI_MAX_FRAME_BITS=32
  - typedef enum logic [1:0] {XC_IDLE, XC_RUN, XC_DONE} xfer_cnt_state_t
- One natural sub-module: sync_flex_counter.
  - Parametrised width, synchronous active-low reset, clear, count_enable, rollover_val, count_out, rollover_flag.
  - Instantiated twice: a bit counter of width FB_W and a frame counter of width LEN_W.
- The top level holds the FSM, config latches and pulse registers.

Test Plan:
- Reset with n_rst=0 across 3 edges, all inputs toggling -> all outputs 0 and state IDLE. Deassert n_rst -> nothing changes until start.
- frame_bits=8, frame_len=3, strobe every other cycle -> frame_done after strobes 8, 16 and 24; xfer_done with the third; frames_done ends at 3; done=1 until the next start.
- frame_bits=1, frame_len=4, strobe every cycle -> 4 consecutive frame_done pulses, xfer_done on the 4th, bit_idx stays 0.
- frame_len=0, start -> next cycle xfer_done=1, done=1, frame_done=0, busy never 1.
- frame_bits=32, frame_len=2; clear on strobe 40 -> next cycle IDLE, bit_idx=0, frames_done=0, no xfer_done. Change frame_bits to 16 mid-RUN in a rerun -> frames are still 32 bits.
- With SPI_XFER_CNT_LAST_EN: frame_bits=4, frame_len=3 -> last_frame rises on the cycle frame_done #2 pulses and falls when done rises. Start+clear in the same cycle -> remains IDLE.
